// File: rtl/magnitude_comparator_pkg.sv
// Shared types and sizing helpers for the chunk-serial magnitude comparator.
package magnitude_comparator_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} mcs_state_t;

  function automatic int mcs_chunks(input int width, input int split);
    return width / split;
  endfunction

  // A single-chunk compare still needs a 1-bit counter so the port widths stay legal.
  function automatic int mcs_cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/magnitude_comparator_slice.sv
// Combinational SPLIT-bit unsigned compare: o_a = a > b, o_b = b > a.
module magnitude_comparator_slice #(
  parameter int SPLIT = 2
) (
  input  logic [SPLIT-1:0] i_a,
  input  logic [SPLIT-1:0] i_b,
  output logic             o_a,
  output logic             o_b
);

  assign o_a = (i_a > i_b);
  assign o_b = (i_b > i_a);

endmodule

// File: rtl/magnitude_comparator_sequencer.sv
// Chunk-serial unsigned magnitude comparator, MSB chunk first, one shared slice.
// Optional MAGNITUDE_COMPARATOR_EARLY_EXIT_EN: leave CMP on the first differing chunk.
module magnitude_comparator_sequencer
  import magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_a,
  output logic             o_b
);

  localparam int CHUNKS = mcs_chunks(WIDTH, SPLIT);
  localparam int CNT_W  = mcs_cnt_w(CHUNKS);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CHUNKS - 1);

  if (WIDTH % SPLIT != 0) begin : g_bad_split
    $error("magnitude_comparator_sequencer: WIDTH must be a multiple of SPLIT");
  end

  mcs_state_t       r_state;
  mcs_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_gt;
  logic             r_lt;
  logic             r_o_vld;
  logic             r_o_a;
  logic             r_o_b;

  logic [SPLIT-1:0] w_chunk_a;
  logic [SPLIT-1:0] w_chunk_b;
  logic             w_sl_gt;
  logic             w_sl_lt;
  logic             w_gt_nxt;
  logic             w_lt_nxt;
  logic             w_last;
  logic             w_accept;

  // Chunk select as an explicit mux keeps every operand bit live for lint.
  always_comb begin
    w_chunk_a = '0;
    w_chunk_b = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_chunk_a = r_a[i*SPLIT +: SPLIT];
        w_chunk_b = r_b[i*SPLIT +: SPLIT];
      end
    end
  end

  magnitude_comparator_slice #(.SPLIT(SPLIT)) u_slice (
    .i_a (w_chunk_a),
    .i_b (w_chunk_b),
    .o_a (w_sl_gt),
    .o_b (w_sl_lt)
  );

  // The most significant differing chunk wins; later chunks cannot override it.
  assign w_gt_nxt = (r_gt || r_lt) ? r_gt : w_sl_gt;
  assign w_lt_nxt = (r_gt || r_lt) ? r_lt : w_sl_lt;

`ifdef MAGNITUDE_COMPARATOR_EARLY_EXIT_EN
  assign w_last = (r_cnt == '0) || w_gt_nxt || w_lt_nxt;
`else
  assign w_last = (r_cnt == '0);
`endif

  assign o_rdy    = rst_n && (r_state == IDLE);
  assign w_accept = i_vld && o_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CMP;
      CMP:     if (w_last)   w_state_nxt = DONE;
      DONE:    if (i_rdy)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= CNT_TOP;
      r_a     <= '0;
      r_b     <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_o_vld <= 1'b0;
      r_o_a   <= 1'b0;
      r_o_b   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= CNT_TOP;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
          end
        end
        CMP: begin
          r_gt  <= w_gt_nxt;
          r_lt  <= w_lt_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_o_a   <= w_gt_nxt;
            r_o_b   <= w_lt_nxt;
            r_o_vld <= 1'b1;
          end
        end
        DONE: begin
          if (i_rdy) r_o_vld <= 1'b0;
        end
        default: r_o_vld <= 1'b0;
      endcase
    end
  end

  assign o_vld = r_o_vld;
  assign o_a   = r_o_a;
  assign o_b   = r_o_b;

  a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(r_o_a && r_o_b))
    else $error("magnitude_comparator_sequencer: o_a and o_b both set");

endmodule

// File: tb/tb_magnitude_comparator_sequencer.sv
// Randomized bench for magnitude_comparator_sequencer (8/2 and 4/4 instances).
module tb_magnitude_comparator_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vld = 1'b0, i_rdy = 1'b0;
  logic [7:0] i_a = '0, i_b = '0;
  logic       o_rdy, o_vld, o_a, o_b;
  logic       i_vld4 = 1'b0, i_rdy4 = 1'b0;
  logic [3:0] i_a4 = '0, i_b4 = '0;
  logic       o_rdy4, o_vld4, o_a4, o_b4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  magnitude_comparator_sequencer #(.WIDTH(8), .SPLIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_a(i_a), .i_b(i_b),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_a(o_a), .o_b(o_b)
  );

  magnitude_comparator_sequencer #(.WIDTH(4), .SPLIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld4), .o_rdy(o_rdy4), .i_a(i_a4), .i_b(i_b4),
    .o_vld(o_vld4), .i_rdy(i_rdy4), .o_a(o_a4), .o_b(o_b4)
  );

  // Reference: latency in edges from accept to o_vld for 8-bit operands in 2-bit chunks.
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MAGNITUDE_COMPARATOR_EARLY_EXIT_EN
    for (int k = 0; k < 4; k++)
      if (((a >> (6 - 2*k)) & 8'd3) != ((b >> (6 - 2*k)) & 8'd3)) return k + 1;
`endif
    return 4;
  endfunction

  // Present a pair and return once the accepting edge has passed.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    i_a = a; i_b = b; i_vld = 1'b1;
    while (!o_rdy && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 50) begin n_errors++; $display("FAIL send_timeout o_rdy=%0b required 1", o_rdy); end
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat = 0;
    while (!o_vld && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== ref_lat(a, b) || o_a !== (a > b) || o_b !== (b > a)) begin
      n_errors++;
      $display("FAIL %s a=%h b=%h lat=%0d o_a=%0b o_b=%0b required lat=%0d o_a=%0b o_b=%0b",
               tag, a, b, lat, o_a, o_b, ref_lat(a, b), a > b, b > a);
    end
  endtask

  task automatic drain();
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_vld !== 1'b0 || o_a !== 1'b0 || o_b !== 1'b0 || o_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state vld=%0b a=%0b b=%0b rdy=%0b required 0 0 0 0", o_vld, o_a, o_b, o_rdy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_rdy !== 1'b1 || o_rdy4 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release rdy=%0b rdy4=%0b required 1 1", o_rdy, o_rdy4);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'hA5, 8'h80, 8'h01};
    logic [7:0] tb [3] = '{8'hA5, 8'h7F, 8'h02};
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb[i]);
      wait_result("directed", ta[i], tb[i]);
      drain();
    end
  endtask

  task automatic test_stall();
    logic sa, sb;
    send(8'h80, 8'h7F);
    wait_result("stall_result", 8'h80, 8'h7F);
    sa = o_a; sb = o_b;
    i_vld = 1'b1; i_a = 8'h00; i_b = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (o_vld !== 1'b1 || o_a !== sa || o_b !== sb || o_rdy !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold cyc=%0d vld=%0b a=%0b b=%0b rdy=%0b required 1 %0b %0b 0",
                 c, o_vld, o_a, o_b, o_rdy, sa, sb);
      end
    end
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0; i_vld = 1'b0;
    n_checks++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_transfer vld=%0b rdy=%0b required 0 1", o_vld, o_rdy);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h01, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (o_vld !== 1'b0 || o_a !== 1'b0 || o_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid vld=%0b a=%0b b=%0b required 0 0 0", o_vld, o_a, o_b);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_mid_rdy rdy=%0b required 1", o_rdy); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (o_vld !== 1'b0) begin n_errors++; $display("FAIL reset_mid_stale cyc=%0d vld=%0b required 0", c, o_vld); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       sa, sb;
    for (int n = 0; n < 1000; n++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       a = b;
        1:       a = b ^ (8'd1 << $urandom_range(0, 7));
        default: a = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(a, b);
      wait_result("random", a, b);
      sa = o_a; sb = o_b;
      for (int c = $urandom_range(0, 3); c > 0; c--) begin
        @(posedge clk); #1;
        n_checks++;
        if (o_vld !== 1'b1 || o_a !== sa || o_b !== sb) begin
          n_errors++;
          $display("FAIL random_hold vld=%0b a=%0b b=%0b required 1 %0b %0b", o_vld, o_a, o_b, sa, sb);
        end
      end
      drain();
    end
  endtask

  // Single-chunk build: every compare takes exactly one CMP cycle.
  task automatic test_variant();
    logic [3:0] a, b;
    int lat;
    for (int n = 0; n < 200; n++) begin
      a = 4'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
      @(negedge clk);
      i_a4 = a; i_b4 = b; i_vld4 = 1'b1;
      @(posedge clk); #1;
      i_vld4 = 1'b0;
      lat = 0;
      while (!o_vld4 && lat < 10) begin @(posedge clk); #1; lat++; end
      n_checks++;
      if (lat !== 1 || o_a4 !== (a > b) || o_b4 !== (b > a)) begin
        n_errors++;
        $display("FAIL variant a=%h b=%h lat=%0d o_a=%0b o_b=%0b required lat=1 o_a=%0b o_b=%0b",
                 a, b, lat, o_a4, o_b4, a > b, b > a);
      end
      i_rdy4 = 1'b1;
      @(posedge clk); #1;
      i_rdy4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_variant();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
